// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
// Arbitration mode is selected by ARB_RR_EN (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_e;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    localparam int unsigned ARB_TIMEOUT_DEF = 16;
    localparam int unsigned WDOG_W          = 8;

endpackage

// File: rtl/mem_port_arbiter_wdog.sv
// Transaction watchdog: 8-bit counter with clear/enable and a terminal count
// flag raised when the count equals TIMEOUT-1.
module arb_wdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic CLRN,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WDOG_W-1:0] TC_VAL = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch (I) and data (D) requesters.
// Define ARB_RR_EN for round-robin; otherwise D has fixed priority over I.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic CLRN,
    input  logic I_REQ,
    input  logic D_REQ,
    input  logic D_WE,
    input  logic MRDY,
    output logic SEL,
    output logic MREQ,
    output logic MWE,
    output logic I_ACK,
    output logic D_ACK,
    output logic ERR,
    output logic BUSY
);

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       mwe_q, mwe_d;
    logic       pick_d;
    logic       in_gnt;
    logic       wdog_tc;

`ifdef ARB_RR_EN
    logic last_q, last_d;

    // Alternate on contention; a lone requester is always served.
    assign pick_d = D_REQ && (!I_REQ || (last_q == SEL_I));

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            last_q <= SEL_D;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (I_REQ || D_REQ)) begin
            last_d = pick_d ? SEL_D : SEL_I;
        end
    end
`else
    assign pick_d = D_REQ;
`endif

    assign in_gnt = (state_q != IDLE);

    arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .CLK   (CLK),
        .CLRN  (CLRN),
        .clr_i (!in_gnt),
        .en_i  (in_gnt && !MRDY),
        .tc_o  (wdog_tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mwe_d   = mwe_q;
        unique case (state_q)
            IDLE: begin
                mwe_d = 1'b0;
                if (pick_d) begin
                    state_d = GNT_D;
                    sel_d   = SEL_D;
                    mwe_d   = D_WE;
                end else if (I_REQ) begin
                    state_d = GNT_I;
                    sel_d   = SEL_I;
                    mwe_d   = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                // MRDY takes precedence over a coincident watchdog expiry.
                if (MRDY || wdog_tc) begin
                    state_d = IDLE;
                    mwe_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                mwe_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= IDLE;
            sel_q   <= SEL_I;
            mwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mwe_q   <= mwe_d;
        end
    end

    assign SEL   = sel_q;
    assign MREQ  = in_gnt;
    assign BUSY  = in_gnt;
    assign MWE   = mwe_q;
    assign I_ACK = (state_q == GNT_I) && MRDY;
    assign D_ACK = (state_q == GNT_D) && MRDY;
    assign ERR   = in_gnt && wdog_tc && !MRDY;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic CLK = 1'b0;
    logic CLRN;
    logic I_REQ, D_REQ, D_WE, MRDY;
    logic SEL, MREQ, MWE, I_ACK, D_ACK, ERR, BUSY;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: who owns the port and how many cycles since grant.
    int   m_owner;   // 0 none, 1 I, 2 D
    int   m_age;     // 1 in the first cycle after grant
    logic m_sel;
    logic m_we;
    logic m_last;    // 1 = D granted most recently

    mem_port_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .CLK   (CLK),
        .CLRN  (CLRN),
        .I_REQ (I_REQ),
        .D_REQ (D_REQ),
        .D_WE  (D_WE),
        .MRDY  (MRDY),
        .SEL   (SEL),
        .MREQ  (MREQ),
        .MWE   (MWE),
        .I_ACK (I_ACK),
        .D_ACK (D_ACK),
        .ERR   (ERR),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {1'b0, SEL, MREQ, MWE, I_ACK, D_ACK, ERR, BUSY};
    endfunction

    function automatic logic [7:0] model_outs(input logic mr);
        logic busy, iack, dack, err;
        busy = (m_owner != 0);
        iack = (m_owner == 1) && mr;
        dack = (m_owner == 2) && mr;
        err  = busy && !mr && (m_age == TO);
        return {1'b0, m_sel, busy, busy && m_we, iack, dack, err, busy};
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_age   = 0;
        m_sel   = 1'b0;
        m_we    = 1'b0;
        m_last  = 1'b1;
    endtask

    task automatic model_step(input logic ir, input logic dr, input logic dwe, input logic mr);
        logic take_d;
        if (m_owner == 0) begin
`ifdef ARB_RR_EN
            take_d = dr && (!ir || !m_last);
`else
            take_d = dr;
`endif
            if (take_d) begin
                m_owner = 2; m_sel = 1'b1; m_we = dwe; m_last = 1'b1; m_age = 1;
            end else if (ir) begin
                m_owner = 1; m_sel = 1'b0; m_we = 1'b0; m_last = 1'b0; m_age = 1;
            end
        end else if (mr || m_age == TO) begin
            m_owner = 0;
        end else begin
            m_age++;
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1), check at negedge, advance model.
    task automatic cycle(input string tag, input logic ir, input logic dr,
                         input logic dwe, input logic mr);
        I_REQ = ir; D_REQ = dr; D_WE = dwe; MRDY = mr;
        @(negedge CLK);
        chk(tag, dut_outs(), model_outs(mr));
        @(posedge CLK);
        model_step(ir, dr, dwe, mr);
        #1;
    endtask

    logic ir, dr, dwe, mr, done;
    int   own;

    initial begin
        CLRN = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0; MRDY = 1'b0;
        model_reset();
        #12;
        chk("reset_outs", dut_outs(), 8'h00);
        @(negedge CLK);
        CLRN = 1'b1;
        @(posedge CLK);
        #1;

        // Fetch with MRDY on the third cycle after grant
        cycle("t1_grant", 1, 0, 0, 0);
        cycle("t1_wait1", 1, 0, 0, 0);
        cycle("t1_wait2", 1, 0, 0, 0);
        cycle("t1_ack",   1, 0, 0, 1);
        cycle("t1_idle",  0, 0, 0, 0);

        // Data write, single-cycle memory
        cycle("t2_grant", 0, 1, 1, 0);
        cycle("t2_ack",   0, 1, 1, 1);
        cycle("t2_idle",  0, 0, 0, 0);

        // Contention for four transactions
        for (int k = 0; k < 4; k++) begin
            cycle("t3_grant", 1, 1, 0, 0);
            cycle("t3_ack",   1, 1, 0, 1);
        end
        cycle("t3_idle",  1, 0, 0, 0);
        cycle("t3_ifin",  1, 0, 0, 1);
        cycle("t3_idle2", 0, 0, 0, 0);

        // Watchdog expiry
        cycle("t4_grant", 0, 1, 0, 0);
        for (int k = 0; k < TO; k++) cycle("t4_wait", 0, 1, 0, 0);
        cycle("t4_idle",  0, 0, 0, 0);

        // MRDY coincident with expiry
        cycle("t5_grant", 0, 1, 0, 0);
        for (int k = 0; k < TO - 1; k++) cycle("t5_wait", 0, 1, 0, 0);
        cycle("t5_ack",   0, 1, 0, 1);
        cycle("t5_idle",  0, 0, 0, 0);

        // MRDY while idle is ignored
        cycle("idle_mrdy", 0, 0, 0, 1);

        // Asynchronous reset during a data write
        cycle("t6_grant", 0, 1, 1, 0);
        cycle("t6_busy",  0, 1, 1, 0);
        CLRN = 1'b0;
        #1;
        chk("t6_async_rst", dut_outs(), 8'h00);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        CLRN = 1'b1; D_REQ = 1'b0; D_WE = 1'b0;
        @(posedge CLK);
        #1;
        cycle("t6_igrant", 1, 0, 0, 0);
        cycle("t6_iack",   1, 0, 0, 1);
        cycle("t6_idle",   0, 0, 0, 0);

        // Randomized traffic obeying the hold-until-ACK/ERR protocol
        ir = 1'b0; dr = 1'b0; dwe = 1'b0;
        for (int n = 0; n < 600; n++) begin
            own  = m_owner;
            mr   = (own != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            done = (own != 0) && (mr || m_age == TO);
            cycle("rand", ir, dr, dwe, mr);
            if (done && own == 1) ir = 1'b0;
            else if (!ir && $urandom_range(0, 1) == 1) ir = 1'b1;
            if (done && own == 2) dr = 1'b0;
            else if (!dr && $urandom_range(0, 1) == 1) begin
                dr  = 1'b1;
                dwe = 1'($urandom_range(0, 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
